// File: rtl/writeback_queue.sv
// writeback_queue
//
// Buffers execution results as (rd, value) pairs and drains them in FIFO
// order, at most one per cycle, onto the register_array write port. It also
// provides two forwarding lookups, so operand fetch can see results that are
// queued but not yet written.
//
// Ports:
//   clk, reset          clock; asynchronous active-high reset
//   flush               synchronous clear of all queued entries
//   in_valid/in_ready   producer handshake; in_rd/in_value carry the result
//   drain_en            write port is available this cycle
//   store/store_value   register_array write port (store == 0 means no write)
//   fwd_sel_*/fwd_hit_*/fwd_value_*  forwarding lookups for operands A and B
//   count               number of valid entries
module writeback_queue #(
  parameter int XLEN       = 32,
  parameter int SELECT_LEN = 5,
  parameter int DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [SELECT_LEN-1:0]      in_rd,
  input  logic [XLEN-1:0]            in_value,
  input  logic                       drain_en,
  output logic [SELECT_LEN-1:0]      store,
  output logic [XLEN-1:0]            store_value,
  input  logic [SELECT_LEN-1:0]      fwd_sel_a,
  output logic                       fwd_hit_a,
  output logic [XLEN-1:0]            fwd_value_a,
  input  logic [SELECT_LEN-1:0]      fwd_sel_b,
  output logic                       fwd_hit_b,
  output logic [XLEN-1:0]            fwd_value_b,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  logic [SELECT_LEN-1:0] rd_mem    [DEPTH];
  logic [XLEN-1:0]       value_mem [DEPTH];

  logic [PTR_W-1:0] head_reg;
  logic [PTR_W-1:0] tail_reg;
  logic [CNT_W-1:0] count_reg;

  logic push;
  logic pop;

  // Slot k is the k-th oldest entry; it is valid when k < count. Walking
  // slots from oldest to newest lets the last match win, which gives
  // newest-entry forwarding.
  logic [PTR_W-1:0] slot_idx   [DEPTH];
  logic [DEPTH-1:0] slot_valid;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot
      assign slot_idx[gi]   = head_reg + PTR_W'(gi);
      assign slot_valid[gi] = (CNT_W'(gi) < count_reg);
    end
  endgenerate

  // Reset clears count asynchronously, so every count-qualified output
  // drops to zero immediately; in_ready needs the explicit reset term.
  assign in_ready = !reset && ((count_reg < FULL_COUNT) || drain_en);
  assign pop      = (count_reg != '0) && drain_en;
  // Entries with rd == 0 are never stored, so pop is equivalent to store != 0.
  assign push     = in_valid && in_ready && (in_rd != '0);
  assign count    = count_reg;

  always_comb begin
    store       = '0;
    store_value = '0;
    if (pop) begin
      store       = rd_mem[head_reg];
      store_value = value_mem[head_reg];
    end
  end

  always_comb begin
    fwd_hit_a   = 1'b0;
    fwd_value_a = '0;
    fwd_hit_b   = 1'b0;
    fwd_value_b = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (slot_valid[k] && (fwd_sel_a != '0) && (rd_mem[slot_idx[k]] == fwd_sel_a)) begin
        fwd_hit_a   = 1'b1;
        fwd_value_a = value_mem[slot_idx[k]];
      end
      if (slot_valid[k] && (fwd_sel_b != '0) && (rd_mem[slot_idx[k]] == fwd_sel_b)) begin
        fwd_hit_b   = 1'b1;
        fwd_value_b = value_mem[slot_idx[k]];
      end
    end
  end

  // Entry storage has no reset; validity is derived from head/count alone.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      rd_mem[tail_reg]    <= in_rd;
      value_mem[tail_reg] <= in_value;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else if (flush) begin
      // Flush wins over any push or pop in the same cycle.
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (push) tail_reg <= tail_reg + 1'b1;
      if (pop)  head_reg <= head_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: tb/tb_writeback_queue.sv
module tb_writeback_queue;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic [31:0] in_value;
  logic        drain_en;
  logic [4:0]  store;
  logic [31:0] store_value;
  logic [4:0]  fwd_sel_a;
  logic        fwd_hit_a;
  logic [31:0] fwd_value_a;
  logic [4:0]  fwd_sel_b;
  logic        fwd_hit_b;
  logic [31:0] fwd_value_b;
  logic [2:0]  count;

  int checks;
  int errors;

  writeback_queue #(.XLEN(32), .SELECT_LEN(5), .DEPTH(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_rd       (in_rd),
    .in_value    (in_value),
    .drain_en    (drain_en),
    .store       (store),
    .store_value (store_value),
    .fwd_sel_a   (fwd_sel_a),
    .fwd_hit_a   (fwd_hit_a),
    .fwd_value_a (fwd_value_a),
    .fwd_sel_b   (fwd_sel_b),
    .fwd_hit_b   (fwd_hit_b),
    .fwd_value_b (fwd_value_b),
    .count       (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [4:0]  exp_rd  [4];
  logic [31:0] exp_val [4];

  initial begin
    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_rd     = '0;
    in_value  = '0;
    drain_en  = 1'b0;
    fwd_sel_a = '0;
    fwd_sel_b = '0;

    // Reset state
    tick();
    check("reset_store", 32'(store), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd0);
    check("reset_count", 32'(count), 32'd0);
    tick();
    reset = 1'b0;
    #1;
    check("post_reset_in_ready", 32'(in_ready), 32'd1);

    // Single push then drain
    in_valid = 1'b1; in_rd = 5'd5; in_value = 32'hDEADBEEF;
    tick();
    in_valid = 1'b0; fwd_sel_a = 5'd5;
    #1;
    check("t1_count", 32'(count), 32'd1);
    check("t1_store_idle", 32'(store), 32'd0);
    check("t1_hit_a", 32'(fwd_hit_a), 32'd1);
    check("t1_val_a", fwd_value_a, 32'hDEADBEEF);
    drain_en = 1'b1;
    #1;
    check("t1_store", 32'(store), 32'd5);
    check("t1_store_value", store_value, 32'hDEADBEEF);
    tick();
    check("t1_count_after", 32'(count), 32'd0);
    check("t1_store_after", 32'(store), 32'd0);
    check("t1_hit_after", 32'(fwd_hit_a), 32'd0);
    drain_en = 1'b0;

    // Fill, hold a fifth push, then push and pop together
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1; in_rd = 5'(i); in_value = 32'(i * 32'h11);
      tick();
    end
    in_rd = 5'd6; in_value = 32'h66;
    #1;
    check("t2_count_full", 32'(count), 32'd4);
    check("t2_in_ready_full", 32'(in_ready), 32'd0);
    tick();
    check("t2_count_held", 32'(count), 32'd4);
    drain_en = 1'b1;
    #1;
    check("t2_in_ready_drain", 32'(in_ready), 32'd1);
    check("t2_store_0", 32'(store), 32'd1);
    check("t2_value_0", store_value, 32'h11);
    tick();
    in_valid = 1'b0;
    check("t2_count_pushpop", 32'(count), 32'd4);
    exp_rd[0] = 5'd2; exp_val[0] = 32'h22;
    exp_rd[1] = 5'd3; exp_val[1] = 32'h33;
    exp_rd[2] = 5'd4; exp_val[2] = 32'h44;
    exp_rd[3] = 5'd6; exp_val[3] = 32'h66;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t2_store_%0d", i + 1), 32'(store), 32'(exp_rd[i]));
      check($sformatf("t2_value_%0d", i + 1), store_value, exp_val[i]);
      tick();
    end
    check("t2_count_empty", 32'(count), 32'd0);
    drain_en = 1'b0;

    // Duplicate rd: newest forwarding, FIFO drain
    in_valid = 1'b1; in_rd = 5'd7; in_value = 32'h1;
    tick();
    in_value = 32'h2;
    tick();
    in_valid = 1'b0; fwd_sel_b = 5'd7;
    #1;
    check("t3_count", 32'(count), 32'd2);
    check("t3_hit_b", 32'(fwd_hit_b), 32'd1);
    check("t3_val_b", fwd_value_b, 32'h2);
    drain_en = 1'b1;
    #1;
    check("t3_store_a", 32'(store), 32'd7);
    check("t3_value_a", store_value, 32'h1);
    tick();
    check("t3_store_b", 32'(store), 32'd7);
    check("t3_value_b", store_value, 32'h2);
    check("t3_val_b_draining", fwd_value_b, 32'h2);
    tick();
    check("t3_count_empty", 32'(count), 32'd0);
    check("t3_hit_b_empty", 32'(fwd_hit_b), 32'd0);
    drain_en = 1'b0;

    // rd = 0 handshake queues nothing
    in_valid = 1'b1; in_rd = 5'd0; in_value = 32'hFFFFFFFF; fwd_sel_a = 5'd0;
    #1;
    check("t4_in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check("t4_count", 32'(count), 32'd0);
    check("t4_hit_a", 32'(fwd_hit_a), 32'd0);

    // Flush drops queue and the concurrent push
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_rd = 5'(10 + i); in_value = 32'(32'hA0 + i);
      tick();
    end
    check("t5_count_pre", 32'(count), 32'd3);
    flush = 1'b1; in_rd = 5'd9; in_value = 32'h99;
    tick();
    flush = 1'b0; in_valid = 1'b0; drain_en = 1'b1;
    fwd_sel_a = 5'd9; fwd_sel_b = 5'd10;
    #1;
    check("t5_count", 32'(count), 32'd0);
    check("t5_store", 32'(store), 32'd0);
    check("t5_hit_a", 32'(fwd_hit_a), 32'd0);
    check("t5_hit_b", 32'(fwd_hit_b), 32'd0);
    drain_en = 1'b0;

    // Asynchronous reset mid-drain
    in_valid = 1'b1; in_rd = 5'd13; in_value = 32'hA;
    tick();
    in_rd = 5'd14; in_value = 32'hB;
    tick();
    in_valid = 1'b0; drain_en = 1'b1; fwd_sel_a = 5'd14;
    #1;
    check("t6_count_pre", 32'(count), 32'd2);
    check("t6_store_pre", 32'(store), 32'd13);
    check("t6_hit_pre", 32'(fwd_hit_a), 32'd1);
    reset = 1'b1;
    #1;
    check("t6_store_rst", 32'(store), 32'd0);
    check("t6_value_rst", store_value, 32'd0);
    check("t6_count_rst", 32'(count), 32'd0);
    check("t6_hit_rst", 32'(fwd_hit_a), 32'd0);
    check("t6_fwd_value_rst", fwd_value_a, 32'd0);
    check("t6_in_ready_rst", 32'(in_ready), 32'd0);
    tick();
    reset = 1'b0; drain_en = 1'b0;
    #1;
    check("t6_in_ready_after", 32'(in_ready), 32'd1);
    check("t6_count_after", 32'(count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/writeback_queue.md
Name: writeback_queue

Overview:
- Write-side producer for `register_array`. It buffers execution results as (rd, value) pairs and drains them in order, at most one per cycle, onto the array's `store`/`store_value` write port.
- Two forwarding lookup ports let the operand-fetch stage see results that are queued but not yet written, so it never reads a stale register.
- Sits between the execute/writeback stage and `register_array`.

Parameters:
- XLEN, 32, data width of register values
- SELECT_LEN, 5, register select width (number of registers = 2**SELECT_LEN)
- DEPTH, 4, number of queue entries; power of two, at least 2

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous active-high reset
- flush  in  1  synchronous clear of all queued entries
- in_valid  in  1  producer has a result
- in_ready  out  1  queue can accept a result this cycle
- in_rd  in  SELECT_LEN  destination register select
- in_value  in  XLEN  result value
- drain_en  in  1  write port available to this block this cycle
- store  out  SELECT_LEN  register_array store select; 0 means no write
- store_value  out  XLEN  register_array store value
- fwd_sel_a  in  SELECT_LEN  lookup select, operand A
- fwd_hit_a  out  1  a queued entry matches fwd_sel_a
- fwd_value_a  out  XLEN  value of the newest matching entry for A
- fwd_sel_b  in  SELECT_LEN  lookup select, operand B
- fwd_hit_b  out  1  a queued entry matches fwd_sel_b
- fwd_value_b  out  XLEN  value of the newest matching entry for B
- count  out  $clog2(DEPTH+1)  number of valid entries

Behaviour:
- State: circular buffer of DEPTH entries {rd, value}, a head pointer, a tail pointer and count. All are registered.
- Reset (asynchronous, any time): head=0, tail=0, count=0, all entries invalid. While reset is high:
  - store=0, store_value=0, fwd_hit_a/b=0, fwd_value_a/b=0, count=0
  - in_ready=0
- Outputs `store` and `store_value` are combinational from registered state and drain_en:
  - if count>0 and drain_en=1: store = head.rd, store_value = head.value
  - otherwise: store=0, store_value=0
- Pop: occurs at the rising edge whenever store≠0. The head advances modulo DEPTH. Each entry is presented for exactly one accepted cycle, and entries drain in FIFO order.
- in_ready = !reset && (count<DEPTH || drain_en). A push into a full queue is allowed only when a pop happens in the same cycle.
- Push: occurs when in_valid && in_ready && in_rd≠0. The entry is written at tail and tail advances modulo DEPTH.
  - in_valid && in_ready with in_rd=0 is a handshake that completes but queues nothing (x0 writes are discarded).
- Push and pop in the same cycle: count is unchanged.
- Count update rule: count_next = count + push − pop. It never exceeds DEPTH and never underflows.
- Flush: at the rising edge, clears head, tail and count.
  - Flush has priority over push and pop in that cycle, so the incoming result is dropped.
  - Combinational outputs in the flush cycle still reflect the pre-flush state. The consumer must hold drain_en low during a flush if that write is unwanted.
- Forwarding (combinational) for each port p in {a, b}:
  - fwd_hit_p = 1 iff fwd_sel_p≠0 and some valid entry has rd==fwd_sel_p.
  - fwd_value_p = value of the newest such entry (closest to tail); 0 when there is no hit.
  - The head entry being drained this cycle is still included, because the array updates only at the edge.
  - The incoming in_* entry of the current cycle is not included.
- Duplicate rd entries are all retained and written in order. The last write wins in the array, which is consistent with newest-match forwarding.
- Pointer wrap: head and tail wrap modulo DEPTH; full vs. empty is decided by count, not by pointer equality.

Test Plan:
- Reset, then push (rd=5, 0xDEADBEEF) with drain_en=0 → count=1, store=0, fwd_sel_a=5 gives hit=1 and value 0xDEADBEEF. Raise drain_en → store=5, store_value=0xDEADBEEF for one cycle, then count=0 and store=0.
- drain_en=0, push rd=1..4 with values 0x11..0x44 → count=4, in_ready=0. A fifth push is held. Raise drain_en with in_valid (rd=6, 0x66) still held → push and pop in the same cycle, count stays 4. Drain order is 1, 2, 3, 4, 6.
- drain_en=0, push (rd=7, 0x1) then (rd=7, 0x2) → fwd_hit_b=1 and fwd_value_b=0x2. Drain both → store=7 with 0x1, then store=7 with 0x2.
- Push rd=0 value 0xFFFFFFFF → handshake completes, count unchanged, fwd_sel_a=0 gives hit=0.
- Queue holds 3 entries, assert flush together with in_valid (rd=9) → next cycle count=0, store=0, no hit for rd=9.
- Assert reset asynchronously mid-drain with count=2 → store, count and fwd_hit drop to 0 immediately without waiting for a clock edge. After release, in_ready=1.
